// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler for the E stage: sequences fixed-latency
// mult/div ops, owns HI/LO, and stalls a dependent D-stage md instruction.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        d_use_md,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] SEL_MULT  = 4'd1;
    localparam logic [3:0] SEL_MULTU = 4'd2;
    localparam logic [3:0] SEL_DIV   = 4'd3;
    localparam logic [3:0] SEL_DIVU  = 4'd4;
    localparam logic [3:0] SEL_MFHI  = 4'd5;
    localparam logic [3:0] SEL_MFLO  = 4'd6;
    localparam logic [3:0] SEL_MTHI  = 4'd7;
    localparam logic [3:0] SEL_MTLO  = 4'd8;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_div0;

    logic             is_md_op;
    logic             is_div_op;
    logic             mt_en;
    logic             commit;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_signed;
    logic [31:0]      dvd;
    logic [31:0]      dvs;
    logic [31:0]      dvs_safe;
    logic [31:0]      uq;
    logic [31:0]      ur;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign is_md_op  = (md_sel >= SEL_MULT) && (md_sel <= SEL_DIVU);
    assign is_div_op = (md_sel == SEL_DIV) || (md_sel == SEL_DIVU);
    assign start     = (state == IDLE) && is_md_op && !flush;
    assign mt_en     = (state == IDLE) && !flush &&
                       ((md_sel == SEL_MTHI) || (md_sel == SEL_MTLO));
    assign busy      = (state == BUSY);
    assign stall_req = d_use_md && (start || busy);
    assign commit    = (state == BUSY) && (cnt == CNT_W'(1)) && !pend_div0;

    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Signed divide runs on magnitudes, then fixes signs: quotient truncates
    // toward zero and the remainder follows the dividend.
    assign div_signed = (md_sel == SEL_DIV);
    assign dvd        = (div_signed && a[31]) ? -a : a;
    assign dvs        = (div_signed && b[31]) ? -b : b;
    assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq         = dvd / dvs_safe;
    assign ur         = dvd % dvs_safe;
    assign quot       = (div_signed && (a[31] ^ b[31])) ? -uq : uq;
    assign rem        = (div_signed && a[31]) ? -ur : ur;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_sel)
            SEL_MULT:  {res_hi, res_lo} = prod_s;
            SEL_MULTU: {res_hi, res_lo} = prod_u;
            SEL_DIV,
            SEL_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BUSY;
                        cnt       <= is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        pend_hi   <= res_hi;
                        pend_lo   <= res_lo;
                        pend_div0 <= is_div_op && (b == 32'd0);
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A divide by zero still runs its full latency but never reaches HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= pend_hi;
            lo <= pend_lo;
        end else if (mt_en) begin
            if (md_sel == SEL_MTHI) begin
                hi <= a;
            end else begin
                lo <= a;
            end
        end
    end

    always_comb begin
        md_out = 32'd0;
        if (md_sel == SEL_MFHI) begin
            md_out = hi;
        end else if (md_sel == SEL_MFLO) begin
            md_out = lo;
        end
    end

endmodule
